// File: rtl/sram_axi_slave_if.sv
// AXI4-Lite style bus between a master and the SRAM slave.
// The slave modport is what sram_axi_slave sees; the master modport drives it.
interface sram_axi_slave_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sram_axi_slave.sv
// AXI-Lite slave bridging single transactions onto a synchronous 16K x 32 SRAM.
// Optional macro SRAM_AXI_DECERR_EN: addresses with bits [31:16] set get DECERR and no SRAM access.
module sram_axi_slave (
  input  logic                  clk,
  input  logic                  rst,
  sram_axi_slave_if.slave       axi,
  output logic                  cs,
  output logic                  oe,
  output logic [3:0]            web,
  output logic [13:0]           a,
  output logic [31:0]           di,
  input  logic [31:0]           sram_do
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    RD_RESP,
    WR_DATA,
    WR_MEM,
    WR_RESP
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [13:0] addr_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic [1:0]  resp_q;
  logic        ar_err;
  logic        aw_err;

`ifdef SRAM_AXI_DECERR_EN
  assign ar_err = |axi.araddr[31:16];
  assign aw_err = |axi.awaddr[31:16];
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (axi.arvalid) begin
            addr_q <= axi.araddr[15:2];
            err_q  <= ar_err;
            resp_q <= ar_err ? 2'b11 : 2'b00;
          end else if (axi.awvalid) begin
            addr_q <= axi.awaddr[15:2];
            err_q  <= aw_err;
            resp_q <= aw_err ? 2'b11 : 2'b00;
          end
        end
        WR_DATA: begin
          if (axi.wvalid) begin
            wdata_q <= axi.wdata;
            wstrb_q <= axi.wstrb;
          end
        end
        RD_WAIT: rdata_q <= err_q ? 32'h0 : sram_do;
        default: ;
      endcase
    end
  end

  // Reads take priority over writes when both address channels are valid in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (axi.arvalid)      next_state = RD_ADDR;
        else if (axi.awvalid) next_state = WR_DATA;
      end
      RD_ADDR: next_state = RD_WAIT;
      RD_WAIT: next_state = RD_RESP;
      RD_RESP: if (axi.rready) next_state = IDLE;
      WR_DATA: if (axi.wvalid) next_state = WR_MEM;
      WR_MEM:  next_state = WR_RESP;
      WR_RESP: if (axi.bready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // rst gates every strobe so a transaction caught by reset stops touching bus and SRAM at once.
  always_comb begin
    axi.arready = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.rvalid  = 1'b0;
    axi.bvalid  = 1'b0;
    cs          = 1'b0;
    oe          = 1'b0;
    web         = 4'b1111;
    if (rst) begin
      case (state)
        IDLE: begin
          axi.arready = 1'b1;
          axi.awready = !axi.arvalid;
        end
        RD_ADDR, RD_WAIT: begin
          cs = !err_q;
          oe = 1'b1;
        end
        RD_RESP: axi.rvalid = 1'b1;
        WR_DATA: axi.wready = 1'b1;
        WR_MEM: begin
          cs  = !err_q;
          web = err_q ? 4'b1111 : ~wstrb_q;
        end
        WR_RESP: axi.bvalid = 1'b1;
        default: ;
      endcase
    end
  end

  assign a         = addr_q;
  assign di        = wdata_q;
  assign axi.rdata = rdata_q;
  assign axi.rresp = resp_q;
  assign axi.bresp = resp_q;

endmodule

// File: tb/tb_sram_axi_slave.sv
// Randomised self-checking bench for sram_axi_slave with an SRAM model and a reference memory.
// Define SRAM_AXI_DECERR_EN for both bench and RTL to exercise the decode-error option.
module tb_sram_axi_slave;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        oe;
  logic [3:0]  web;
  logic [13:0] a;
  logic [31:0] di;
  logic [31:0] sram_do;

  int tests;
  int failures;
  int wr_cycles;

  logic [31:0] sram    [16384];
  logic [31:0] ref_mem [16384];

  sram_axi_slave_if axi();

  sram_axi_slave dut (
    .clk(clk),
    .rst(rst),
    .axi(axi),
    .cs(cs),
    .oe(oe),
    .web(web),
    .a(a),
    .di(di),
    .sram_do(sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after the address is sampled.
  always @(posedge clk) begin
    if (cs) begin
      if (oe) sram_do <= sram[a];
      if (web != 4'hF) wr_cycles++;
      for (int b = 0; b < 4; b++)
        if (!web[b]) sram[a][b*8 +: 8] <= di[b*8 +: 8];
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic decerrOf(input logic [31:0] addr);
`ifdef SRAM_AXI_DECERR_EN
    return addr[31:16] != 16'h0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int bdelay);
    int          budget;
    logic        err;
    logic [13:0] idx;
    err = decerrOf(addr);
    idx = addr[15:2];
    axi.awaddr  = addr;
    axi.awvalid = 1'b1;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.wvalid  = 1'b1;
    axi.bready  = 1'b0;
    #1;
    budget = 0;
    while (!axi.awready && budget < 20) begin stepCycle(); budget++; end
    if (!axi.awready) begin
      checkOutput("aw_timeout", 32'd0, 32'd1);
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      return;
    end
    stepCycle();
    axi.awvalid = 1'b0;
    budget = 0;
    while (!axi.wready && budget < 20) begin stepCycle(); budget++; end
    if (!axi.wready) begin
      checkOutput("w_timeout", 32'd0, 32'd1);
      axi.wvalid = 1'b0;
      return;
    end
    stepCycle();
    axi.wvalid = 1'b0;
    checkOutput("wr_cs", {31'd0, cs}, {31'd0, !err});
    checkOutput("wr_oe", {31'd0, oe}, 32'd0);
    checkOutput("wr_web", {28'd0, web}, err ? 32'hF : {28'd0, ~strb});
    if (!err) begin
      checkOutput("wr_a", {18'd0, a}, {18'd0, idx});
      checkOutput("wr_di", di, data);
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    stepCycle();
    checkOutput("wr_cs_single", {31'd0, cs}, 32'd0);
    checkOutput("bvalid_rise", {31'd0, axi.bvalid}, 32'd1);
    checkOutput("bresp", {30'd0, axi.bresp}, err ? 32'd3 : 32'd0);
    repeat (bdelay) stepCycle();
    if (bdelay > 0) checkOutput("bvalid_hold", {31'd0, axi.bvalid}, 32'd1);
    axi.bready = 1'b1;
    stepCycle();
    axi.bready = 1'b0;
    checkOutput("bvalid_fall", {31'd0, axi.bvalid}, 32'd0);
  endtask

  task automatic axiRead(input logic [31:0] addr, input int rdelay);
    int          budget;
    logic        err;
    logic [13:0] idx;
    logic [31:0] exp;
    err = decerrOf(addr);
    idx = addr[15:2];
    exp = err ? 32'h0 : ref_mem[idx];
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b0;
    #1;
    budget = 0;
    while (!axi.arready && budget < 20) begin stepCycle(); budget++; end
    if (!axi.arready) begin
      checkOutput("ar_timeout", 32'd0, 32'd1);
      axi.arvalid = 1'b0;
      return;
    end
    stepCycle();
    axi.arvalid = 1'b0;
    checkOutput("rd1_rvalid", {31'd0, axi.rvalid}, 32'd0);
    checkOutput("rd1_cs", {31'd0, cs}, {31'd0, !err});
    checkOutput("rd1_oe", {31'd0, oe}, 32'd1);
    checkOutput("rd1_web", {28'd0, web}, 32'hF);
    checkOutput("rd1_a", {18'd0, a}, {18'd0, idx});
    checkOutput("rd1_awready", {31'd0, axi.awready}, 32'd0);
    stepCycle();
    checkOutput("rd2_rvalid", {31'd0, axi.rvalid}, 32'd0);
    checkOutput("rd2_cs", {31'd0, cs}, {31'd0, !err});
    stepCycle();
    checkOutput("rd3_rvalid", {31'd0, axi.rvalid}, 32'd1);
    checkOutput("rdata", axi.rdata, exp);
    checkOutput("rresp", {30'd0, axi.rresp}, err ? 32'd3 : 32'd0);
    repeat (rdelay) stepCycle();
    if (rdelay > 0) begin
      checkOutput("rvalid_hold", {31'd0, axi.rvalid}, 32'd1);
      checkOutput("rdata_hold", axi.rdata, exp);
    end
    axi.rready = 1'b1;
    stepCycle();
    axi.rready = 1'b0;
    checkOutput("rvalid_fall", {31'd0, axi.rvalid}, 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_arready"}, {31'd0, axi.arready}, 32'd0);
    checkOutput({tag, "_awready"}, {31'd0, axi.awready}, 32'd0);
    checkOutput({tag, "_wready"},  {31'd0, axi.wready}, 32'd0);
    checkOutput({tag, "_bvalid"},  {31'd0, axi.bvalid}, 32'd0);
    checkOutput({tag, "_rvalid"},  {31'd0, axi.rvalid}, 32'd0);
    checkOutput({tag, "_bresp"},   {30'd0, axi.bresp}, 32'd0);
    checkOutput({tag, "_rresp"},   {30'd0, axi.rresp}, 32'd0);
    checkOutput({tag, "_rdata"},   axi.rdata, 32'd0);
    checkOutput({tag, "_cs"},      {31'd0, cs}, 32'd0);
    checkOutput({tag, "_oe"},      {31'd0, oe}, 32'd0);
    checkOutput({tag, "_web"},     {28'd0, web}, 32'hF);
    checkOutput({tag, "_a"},       {18'd0, a}, 32'd0);
    checkOutput({tag, "_di"},      di, 32'd0);
  endtask

  initial begin
    int          wr_before;
    logic [31:0] addr;
    tests       = 0;
    failures    = 0;
    wr_cycles   = 0;
    rst         = 1'b0;
    axi.awaddr  = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.araddr  = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      sram[i]    = i * 32'h9E37_79B9;
      ref_mem[i] = i * 32'h9E37_79B9;
    end

    repeat (3) stepCycle();
    checkResetOutputs("reset");
    rst = 1'b1;
    stepCycle();
    checkOutput("post_reset_arready", {31'd0, axi.arready}, 32'd1);

    applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    axiRead(32'h0000_0010, 5);
    applyStimulus(32'h0000_0010, 32'h00AB_0000, 4'b0100, 1);
    axiRead(32'h0000_0010, 0);
    checkOutput("byte2_model", ref_mem[4], 32'hDEAB_BEEF);

    // Collision: both address channels valid together, read must win.
    axi.awaddr  = 32'h0000_0024;
    axi.awvalid = 1'b1;
    axi.araddr  = 32'h0000_0010;
    axi.arvalid = 1'b1;
    #1;
    checkOutput("collide_arready", {31'd0, axi.arready}, 32'd1);
    checkOutput("collide_awready", {31'd0, axi.awready}, 32'd0);
    axiRead(32'h0000_0010, 1);
    applyStimulus(32'h0000_0024, 32'h1234_5678, 4'hF, 0);
    axiRead(32'h0000_0024, 0);

    // Reset while waiting for write data: no SRAM write and no response.
    axi.awaddr  = 32'h0000_0030;
    axi.awvalid = 1'b1;
    #1;
    stepCycle();
    axi.awvalid = 1'b0;
    checkOutput("rst_wr_wready", {31'd0, axi.wready}, 32'd1);
    wr_before  = wr_cycles;
    rst        = 1'b0;
    axi.wdata  = 32'hCAFE_F00D;
    axi.wstrb  = 4'hF;
    axi.wvalid = 1'b1;
    stepCycle();
    checkResetOutputs("midrst");
    rst        = 1'b1;
    axi.wvalid = 1'b0;
    stepCycle();
    checkOutput("midrst_arready", {31'd0, axi.arready}, 32'd1);
    repeat (4) stepCycle();
    checkOutput("midrst_bvalid", {31'd0, axi.bvalid}, 32'd0);
    checkOutput("midrst_no_write", wr_cycles, wr_before);
    axiRead(32'h0000_0030, 0);

`ifdef SRAM_AXI_DECERR_EN
    axiRead(32'h0001_0000, 2);
    applyStimulus(32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 1);
    axiRead(32'h0000_0000, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      addr[31:16] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
      addr[15:2]  = 14'($urandom_range(0, 15));
      addr[1:0]   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        applyStimulus(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      else
        axiRead(addr, $urandom_range(0, 3));
    end

    for (int i = 0; i < 16; i++) axiRead(32'(i * 4), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
